// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: push control, read-pointer sync, full/almost-full/fill.
// Optional sticky overflow flag: define FIFO_WR_OVERFLOW_EN to add the wr_overflow port.
module fifo_wr_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_din,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_fill
`ifdef FIFO_WR_OVERFLOW_EN
    ,
    output logic                  wr_overflow
`endif
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_MARGIN);
    // Inverting the two top Gray bits maps "same slot, one lap ahead" onto equality.
    localparam logic [PW-1:0] FULL_XOR    = PW'(3) << (PW - 2);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("fifo_wr_ctrl: SYNC_STAGES must be 2..4");
    end
    if (ADDR_WIDTH < 2) begin : g_bad_addr
        $error("fifo_wr_ctrl: ADDR_WIDTH must be at least 2");
    end
    if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("fifo_wr_ctrl: AFULL_MARGIN must be 1..DEPTH-1");
    end

    logic [PW-1:0]                  wr_bin;
    logic [PW-1:0]                  wr_bin_next;
    logic [PW-1:0]                  wr_gray_next;
    logic [PW-1:0]                  fill_next;
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  rq_sync;
    logic [PW-1:0]                  rq_bin;
    logic                           push;

    assign push    = wr_req & ~full;
    assign wr_en   = push;
    assign wr_addr = wr_bin[ADDR_WIDTH-1:0];
    assign wr_data = wr_din;

    assign rq_sync = sync_q[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < PW; i++) begin : g_g2b
        assign rq_bin[i] = ^(rq_sync >> i);
    end

    // Next-state pointer, fill and flag terms share one computation so push and read advance fold together.
    always_comb begin
        wr_bin_next  = wr_bin + PW'(push);
        wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
        fill_next    = wr_bin_next - rq_bin;
    end

    // Read-pointer synchroniser chain.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Pointer and status registers.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_fill     <= '0;
        end else begin
            wr_bin      <= wr_bin_next;
            wr_ptr_gray <= wr_gray_next;
            full        <= (wr_gray_next == (rq_sync ^ FULL_XOR));
            almost_full <= (fill_next >= AFULL_LEVEL);
            wr_fill     <= fill_next;
        end
    end

`ifdef FIFO_WR_OVERFLOW_EN
    // Sticky record of any request made while full.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_overflow <= 1'b0;
        end else if (wr_req && full) begin
            wr_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: stimulus queues expected writes/status, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_fifo_wr_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n;
    logic          wr_req;
    logic [DW-1:0] wr_din;
    logic [PW-1:0] rd_ptr_gray;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [PW-1:0] wr_ptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_fill;
`ifdef FIFO_WR_OVERFLOW_EN
    logic          wr_overflow;
`endif

    fifo_wr_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (2),
        .AFULL_MARGIN(2)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst_n    (wr_rst_n),
        .wr_req      (wr_req),
        .wr_din      (wr_din),
        .rd_ptr_gray (rd_ptr_gray),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wr_fill     (wr_fill)
`ifdef FIFO_WR_OVERFLOW_EN
        ,
        .wr_overflow (wr_overflow)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        int            at;
        string         name;
        logic [PW-1:0] gray;
        logic          full;
        logic          af;
        logic [PW-1:0] fill;
        logic [AW-1:0] addr;
        logic          en;
        logic          chk_fill;
        logic          ovf;
    } st_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    st_t sq[$];
    wr_t wq[$];
    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_pass = 0;
    int  wraps  = 0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge wr_clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] gray_of(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic exp_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        wq.push_back(w);
    endtask

    // Expected state after the most recent edge, checked by the monitor on the following negedge.
    task automatic exp_st(input string name, input logic [PW-1:0] g, input logic f, input logic af,
                          input logic [PW-1:0] fill, input logic [AW-1:0] addr,
                          input logic cf, input logic ovf);
        st_t s;
        s.at = cyc; s.name = name; s.gray = g; s.full = f; s.af = af; s.fill = fill;
        s.addr = addr; s.en = wr_req & ~f; s.chk_fill = cf; s.ovf = ovf;
        sq.push_back(s);
    endtask

    // Monitor: every presented write pops the write queue; due status items are compared.
    st_t mon_s;
    wr_t mon_w;
    logic mon_ok;
    always @(negedge wr_clk) begin
        if (wr_en) begin
            n_chk++;
            if (wq.size() == 0) begin
                $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h, required no write", cyc, wr_addr, wr_data);
            end else begin
                mon_w = wq.pop_front();
                if (wr_addr === mon_w.addr && wr_data === mon_w.data) n_pass++;
                else $display("FAIL write cyc=%0d got addr=%0d data=%h, required addr=%0d data=%h",
                              cyc, wr_addr, wr_data, mon_w.addr, mon_w.data);
            end
            if (prev_addr == AW'(15) && wr_addr == '0) wraps++;
            prev_addr = wr_addr;
        end
        while (sq.size() > 0 && sq[0].at <= cyc) begin
            mon_s = sq.pop_front();
            n_chk++;
            mon_ok = (wr_ptr_gray === mon_s.gray) && (full === mon_s.full) &&
                     (wr_addr === mon_s.addr) && (wr_en === mon_s.en) &&
                     (!mon_s.chk_fill || (wr_fill === mon_s.fill && almost_full === mon_s.af));
`ifdef FIFO_WR_OVERFLOW_EN
            mon_ok = mon_ok && (wr_overflow === mon_s.ovf);
`endif
            if (mon_ok) n_pass++;
            else $display("FAIL %s cyc=%0d got gray=%b full=%b af=%b fill=%0d addr=%0d en=%b, required gray=%b full=%b af=%b fill=%0d addr=%0d en=%b ovf=%b (fill/af checked=%b)",
                          mon_s.name, cyc, wr_ptr_gray, full, almost_full, wr_fill, wr_addr, wr_en,
                          mon_s.gray, mon_s.full, mon_s.af, mon_s.fill, mon_s.addr, mon_s.en, mon_s.ovf, mon_s.chk_fill);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    logic [PW-1:0] wb;
    logic [PW-1:0] rb;

    initial begin
        wr_rst_n = 1'b0; wr_req = 1'b0; wr_din = '0; rd_ptr_gray = '0;
        step(); step();
        exp_st("reset", '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step();
        wr_rst_n = 1'b1;
        step();

        // Five pushes, then an asynchronous reset checked before any further clock edge.
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_din = DW'(8'hA0 + i);
            exp_wr(AW'(i), wr_din);
            exp_st("pre_rst_push", gray_of(PW'(i)), 1'b0, 1'b0, PW'(i), AW'(i), 1'b1, 1'b0);
            step();
        end
        wr_req = 1'b0;
        exp_st("after5", 5'b00111, 1'b0, 1'b0, 5'd5, 4'd5, 1'b1, 1'b0);
        step();
        wr_rst_n = 1'b0;
        exp_st("async_rst", '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step();
        wr_rst_n = 1'b1;
        step();

        // Fill to full with the read pointer parked at zero.
        for (int i = 0; i < 16; i++) begin
            wr_req = 1'b1; wr_din = DW'(8'h10 + i);
            exp_wr(AW'(i), wr_din);
            exp_st("fill", gray_of(PW'(i)), 1'b0, (i >= 14), PW'(i), AW'(i), 1'b1, 1'b0);
            step();
        end
        exp_st("full_17th", 5'b11000, 1'b1, 1'b1, 5'd16, 4'd0, 1'b1, 1'b0);
        step();
        wr_req = 1'b0;
        exp_st("full_held", 5'b11000, 1'b1, 1'b1, 5'd16, 4'd0, 1'b1, 1'b1);
        step();

        // Full release after a one-entry read: clears on the third edge.
        rd_ptr_gray = 5'b00001;
        exp_st("rel_e0", 5'b11000, 1'b1, 1'b1, 5'd16, 4'd0, 1'b1, 1'b1);
        step();
        exp_st("rel_e1", 5'b11000, 1'b1, 1'b1, 5'd16, 4'd0, 1'b1, 1'b1);
        step();
        exp_st("rel_e2", 5'b11000, 1'b1, 1'b1, 5'd16, 4'd0, 1'b1, 1'b1);
        step();
        wr_req = 1'b1; wr_din = 8'h5A;
        exp_wr(4'd0, 8'h5A);
        exp_st("rel_e3", 5'b11000, 1'b0, 1'b1, 5'd15, 4'd0, 1'b1, 1'b1);
        step();
        wr_req = 1'b0;
        exp_st("refull", 5'b11001, 1'b1, 1'b1, 5'd16, 4'd1, 1'b1, 1'b1);
        step();

        // Simultaneous push and synchronised read advance at fill 8.
        wr_rst_n = 1'b0; rd_ptr_gray = '0;
        exp_st("rst2", '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step();
        wr_rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            wr_req = 1'b1; wr_din = DW'(8'h30 + i);
            exp_wr(AW'(i), wr_din);
            exp_st("to8", gray_of(PW'(i)), 1'b0, 1'b0, PW'(i), AW'(i), 1'b1, 1'b0);
            step();
        end
        wr_req = 1'b0; rd_ptr_gray = 5'b00001;
        exp_st("sim_c0", 5'b01100, 1'b0, 1'b0, 5'd8, 4'd8, 1'b1, 1'b0);
        step();
        exp_st("sim_c1", 5'b01100, 1'b0, 1'b0, 5'd8, 4'd8, 1'b1, 1'b0);
        step();
        wr_req = 1'b1; wr_din = 8'hC3;
        exp_wr(4'd8, 8'hC3);
        exp_st("sim_c2", 5'b01100, 1'b0, 1'b0, 5'd8, 4'd8, 1'b1, 1'b0);
        step();
        wr_req = 1'b0;
        exp_st("sim_push", 5'b01101, 1'b0, 1'b0, 5'd8, 4'd9, 1'b1, 1'b0);
        step();

        // Wrap: 40 pushes with the read pointer trailing one Gray step at a time.
        wr_rst_n = 1'b0; rd_ptr_gray = '0;
        step();
        wr_rst_n = 1'b1;
        step();
        wraps = 0; prev_addr = '0;
        wb = '0; rb = '0;
        for (int i = 0; i < 40; i++) begin
            wr_req = 1'b1; wr_din = DW'(i * 7);
            exp_wr(wb[AW-1:0], wr_din);
            exp_st("wrap", gray_of(wb), 1'b0, 1'b0, '0, wb[AW-1:0], 1'b0, 1'b0);
            if (PW'(wb - rb) > PW'(3)) begin
                rb = rb + PW'(1);
                rd_ptr_gray = gray_of(rb);
            end
            step();
            wb = wb + PW'(1);
        end
        wr_req = 1'b0;
        exp_st("wrap_end", 5'b01100, 1'b0, 1'b0, '0, 4'd8, 1'b0, 1'b0);
        step(); step(); step();

        n_chk++;
        if (wraps == 2) n_pass++;
        else $display("FAIL wrap_count got %0d wraps, required 2", wraps);
        n_chk++;
        if (wq.size() == 0 && sq.size() == 0) n_pass++;
        else $display("FAIL drain got %0d writes and %0d status items outstanding, required 0 and 0", wq.size(), sq.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
